// File: rtl/pipe_ctrl_unit_v2.sv
// pipe_ctrl_unit_v2: MIPS ID decode plus E/M/W control pipeline with
// stall/flush, valid tracking, retire counter, sticky illegal flag and debug mux.
module pipe_ctrl_unit_v2 #(
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opD,
    input  logic [5:0]        funcD,
    input  logic              validD,
    input  logic              equalD,
    input  logic              flushE,
    input  logic              stallE,
    input  logic [2:0]        sel,
    output logic              pcsrcD,
    output logic              branchD,
    output logic              jumpD,
    output logic              illegalD,
    output logic              alusrcE,
    output logic              regdstE,
    output logic              shiftE,
    output logic              regwriteE,
    output logic              mem2regE,
    output logic [ALUC_W-1:0] alucontrolE,
    output logic              memwriteM,
    output logic              regwriteM,
    output logic              mem2regM,
    output logic              regwriteW,
    output logic              mem2regW,
    output logic              validE,
    output logic              validM,
    output logic              validW,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              illegal_seen,
    output logic [31:0]       disdata
);
    localparam int EW = ALUC_W + 7;

    logic regwrite, regdst, alusrc, mem2reg, memwrite, branch, jump, shift, ill;
    logic [3:0] aluc;
    logic memwriteE;
    logic [EW-1:0] e_q;
    logic [3:0] m_q;
    logic [2:0] w_q;
    logic [31:0] rep_op, rep_fn;

    always_comb begin
        {regwrite, regdst, alusrc, mem2reg, memwrite, branch, jump, shift, ill} = '0;
        aluc = 4'b0000;
        case (opD)
            6'b000000: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                case (funcD)
                    6'b100000: aluc = 4'b0010;
                    6'b100010: aluc = 4'b0110;
                    6'b100100: aluc = 4'b0000;
                    6'b100101: aluc = 4'b0001;
                    6'b101010: aluc = 4'b0111;
                    6'b000000: begin aluc = 4'b1000; shift = 1'b1; end
                    6'b000010: begin aluc = 4'b1001; shift = 1'b1; end
                    default:   ill = 1'b1;
                endcase
            end
            6'b100011: begin regwrite = 1'b1; alusrc = 1'b1; mem2reg = 1'b1; aluc = 4'b0010; end
            6'b101011: begin memwrite = 1'b1; alusrc = 1'b1; aluc = 4'b0010; end
            6'b000100, 6'b000101: begin branch = 1'b1; aluc = 4'b0110; end
            6'b001000: begin regwrite = 1'b1; alusrc = 1'b1; aluc = 4'b0010; end
            6'b001100: begin regwrite = 1'b1; alusrc = 1'b1; aluc = 4'b0000; end
            6'b001101: begin regwrite = 1'b1; alusrc = 1'b1; aluc = 4'b0001; end
            6'b001010: begin regwrite = 1'b1; alusrc = 1'b1; aluc = 4'b0111; end
            6'b000010: jump = 1'b1;
            default:   ill = 1'b1;
        endcase
        if (ill || !validD) begin
            {regwrite, regdst, alusrc, mem2reg, memwrite, branch, jump, shift} = '0;
            aluc = 4'b0000;
        end
    end

    // beq and bne differ only in opcode bit 0
    assign branchD  = branch;
    assign jumpD    = jump;
    assign illegalD = ill & validD;
    assign pcsrcD   = branch & (opD[0] ? ~equalD : equalD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q          <= '0;
            m_q          <= '0;
            w_q          <= '0;
            retire_cnt   <= '0;
            illegal_seen <= 1'b0;
        end else begin
            e_q <= flushE ? '0 : stallE ? e_q :
                   {validD, alusrc, regdst, shift, regwrite, mem2reg, memwrite, ALUC_W'(aluc)};
            // a held E must not also advance into M, or it would execute twice
            m_q          <= (stallE && !flushE) ? '0 : {validE, memwriteE, regwriteE, mem2regE};
            w_q          <= {m_q[3], m_q[1], m_q[0]};
            retire_cnt   <= retire_cnt + CNT_W'(validW);
            illegal_seen <= illegal_seen | (illegalD & ~flushE & ~stallE);
        end
    end

    assign {validE, alusrcE, regdstE, shiftE, regwriteE, mem2regE, memwriteE, alucontrolE} = e_q;
    assign {validM, memwriteM, regwriteM, mem2regM} = m_q;
    assign {validW, regwriteW, mem2regW} = w_q;

    always_comb begin
        rep_op = '0;
        rep_fn = '0;
        for (int i = 0; i < 6; i++) begin
            rep_op[4*i +: 4] = {4{opD[i]}};
            rep_fn[4*i +: 4] = {4{funcD[i]}};
        end
    end

    assign disdata = sel == 3'd0 ? {3'b0, mem2regE, 3'b0, mem2regM, 3'b0, mem2regW, 3'b0, branchD,
                                    3'b0, regwriteE, 3'b0, regwriteM, 3'b0, regwriteW, 3'b0, regdstE}
                   : sel == 3'd1 ? rep_op
                   : sel == 3'd2 ? rep_fn
                   : sel == 3'd3 ? {8{alucontrolE[3:0]}}
                   : sel == 3'd4 ? 32'(retire_cnt)
                   : sel == 3'd5 ? {illegal_seen, 28'b0, validE, validM, validW}
                   : 32'b0;
endmodule

// File: tb/tb_pipe_ctrl_unit_v2.sv
// tb_pipe_ctrl_unit_v2: directed and random checks of pipe_ctrl_unit_v2 against
// an instruction-level pipeline model (retire counter narrowed to 2 bits).
module tb_pipe_ctrl_unit_v2;
    localparam int CW = 2;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [5:0] opD = '0, funcD = '0;
    logic validD = 1'b0, equalD = 1'b0, flushE = 1'b0, stallE = 1'b0;
    logic [2:0] sel = '0;
    logic pcsrcD, branchD, jumpD, illegalD, alusrcE, regdstE, shiftE, regwriteE, mem2regE;
    logic [3:0] alucontrolE;
    logic memwriteM, regwriteM, mem2regM, regwriteW, mem2regW, validE, validM, validW;
    logic [CW-1:0] retire_cnt;
    logic illegal_seen;
    logic [31:0] disdata;

    pipe_ctrl_unit_v2 #(.ALUC_W(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(rst_n), .opD(opD), .funcD(funcD), .validD(validD), .equalD(equalD),
        .flushE(flushE), .stallE(stallE), .sel(sel), .pcsrcD(pcsrcD), .branchD(branchD),
        .jumpD(jumpD), .illegalD(illegalD), .alusrcE(alusrcE), .regdstE(regdstE),
        .shiftE(shiftE), .regwriteE(regwriteE), .mem2regE(mem2regE), .alucontrolE(alucontrolE),
        .memwriteM(memwriteM), .regwriteM(regwriteM), .mem2regM(mem2regM),
        .regwriteW(regwriteW), .mem2regW(mem2regW), .validE(validE), .validM(validM),
        .validW(validW), .retire_cnt(retire_cnt), .illegal_seen(illegal_seen), .disdata(disdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic valid, alusrc, regdst, shift, regwrite, mem2reg, memwrite, branch, jump, ill;
        logic [3:0] alu;
    } ctrl_t;

    ctrl_t me, mm, mw;
    logic [CW-1:0] mcnt;
    logic mill;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // instruction table: mnemonic-level meaning of each opcode/funct
    function automatic ctrl_t dec(input logic [5:0] op, input logic [5:0] f, input logic v);
        ctrl_t c;
        c = '0;
        c.valid = v;
        if (op == 6'h00) begin
            c.regwrite = 1; c.regdst = 1;
            if (f == 6'h20) c.alu = 4'd2;
            else if (f == 6'h22) c.alu = 4'd6;
            else if (f == 6'h24) c.alu = 4'd0;
            else if (f == 6'h25) c.alu = 4'd1;
            else if (f == 6'h2a) c.alu = 4'd7;
            else if (f == 6'h00) begin c.alu = 4'd8; c.shift = 1; end
            else if (f == 6'h02) begin c.alu = 4'd9; c.shift = 1; end
            else c.ill = 1;
        end
        else if (op == 6'h23) begin c.regwrite = 1; c.alusrc = 1; c.mem2reg = 1; c.alu = 4'd2; end
        else if (op == 6'h2b) begin c.memwrite = 1; c.alusrc = 1; c.alu = 4'd2; end
        else if (op == 6'h04 || op == 6'h05) begin c.branch = 1; c.alu = 4'd6; end
        else if (op == 6'h08) begin c.regwrite = 1; c.alusrc = 1; c.alu = 4'd2; end
        else if (op == 6'h0c) begin c.regwrite = 1; c.alusrc = 1; c.alu = 4'd0; end
        else if (op == 6'h0d) begin c.regwrite = 1; c.alusrc = 1; c.alu = 4'd1; end
        else if (op == 6'h0a) begin c.regwrite = 1; c.alusrc = 1; c.alu = 4'd7; end
        else if (op == 6'h02) c.jump = 1;
        else c.ill = 1;
        if (!v) c = '0;
        else if (c.ill) begin c = '0; c.valid = 1; c.ill = 1; end
        return c;
    endfunction

    function automatic logic [31:0] dis(input logic [2:0] s, input ctrl_t d,
                                         input logic [5:0] op, input logic [5:0] f);
        logic [31:0] r;
        logic [7:0] fl;
        r = '0;
        fl = {me.mem2reg, mm.mem2reg, mw.mem2reg, d.branch, me.regwrite, mm.regwrite, mw.regwrite, me.regdst};
        if (s == 0) for (int i = 0; i < 8; i++) r[4*i] = fl[i];
        if (s == 1) for (int i = 0; i < 6; i++) r[4*i +: 4] = {4{op[i]}};
        if (s == 2) for (int i = 0; i < 6; i++) r[4*i +: 4] = {4{f[i]}};
        if (s == 3) for (int i = 0; i < 8; i++) r[4*i +: 4] = me.alu;
        if (s == 4) r = 32'(mcnt);
        if (s == 5) r = {mill, 28'b0, me.valid, mm.valid, mw.valid};
        return r;
    endfunction

    task automatic check_state();
        chk("alusrcE", alusrcE, me.alusrc);
        chk("regdstE", regdstE, me.regdst);
        chk("shiftE", shiftE, me.shift);
        chk("regwriteE", regwriteE, me.regwrite);
        chk("mem2regE", mem2regE, me.mem2reg);
        chk("alucontrolE", alucontrolE, me.alu);
        chk("validE", validE, me.valid);
        chk("memwriteM", memwriteM, mm.memwrite);
        chk("regwriteM", regwriteM, mm.regwrite);
        chk("mem2regM", mem2regM, mm.mem2reg);
        chk("validM", validM, mm.valid);
        chk("regwriteW", regwriteW, mw.regwrite);
        chk("mem2regW", mem2regW, mw.mem2reg);
        chk("validW", validW, mw.valid);
        chk("retire_cnt", retire_cnt, mcnt);
        chk("illegal_seen", illegal_seen, mill);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] f, input logic v,
                         input logic eq, input logic fl, input logic st, input logic [2:0] s);
        opD = op; funcD = f; validD = v; equalD = eq; flushE = fl; stallE = st; sel = s;
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] f, input logic v,
                        input logic eq, input logic fl, input logic st, input logic [2:0] s);
        ctrl_t d;
        drive(op, f, v, eq, fl, st, s);
        #1;
        d = dec(op, f, v);
        chk("branchD", branchD, d.branch);
        chk("jumpD", jumpD, d.jump);
        chk("illegalD", illegalD, d.ill);
        chk("pcsrcD", pcsrcD, d.branch & ((op == 6'h04) ? eq : ~eq));
        chk("disdata", disdata, dis(s, d, op, f));
        @(posedge clk);
        if (d.ill && !fl && !st) mill = 1'b1;
        if (mw.valid) mcnt = mcnt + 1'b1;
        mw = mm;
        mm = (st && !fl) ? '0 : me;
        me = fl ? '0 : st ? me : d;
        #1;
        check_state();
    endtask

    task automatic model_reset();
        me = '0; mm = '0; mw = '0; mcnt = '0; mill = 1'b0;
    endtask

    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h02};
    logic [5:0] fns [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02};
    int exp_cnt [8] = '{0, 0, 0, 1, 2, 3, 0, 1};

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        sel = 3'd5; #1;
        check_state();
        chk("rst_dis5", disdata, 32'h0);
        #4 rst_n = 1'b1;

        step(6'h23, 6'h00, 1, 0, 0, 0, 0);
        chk("lw_m2rE", mem2regE, 1);
        step(6'h00, 6'h00, 0, 0, 0, 0, 0);
        chk("lw_m2rM", mem2regM, 1);
        chk("lw_mwM", memwriteM, 0);
        step(6'h00, 6'h00, 0, 0, 0, 0, 0);
        chk("lw_m2rW", mem2regW, 1);
        chk("lw_rwW", regwriteW, 1);
        step(6'h00, 6'h00, 0, 0, 0, 0, 4);
        chk("lw_retire", retire_cnt, 1);

        drive(6'h04, 6'h00, 1, 1, 0, 0, 0); #1 chk("beq_eq", pcsrcD, 1);
        step(6'h04, 6'h00, 1, 1, 0, 0, 0);
        drive(6'h05, 6'h00, 1, 1, 0, 0, 0); #1 chk("bne_eq", pcsrcD, 0);
        step(6'h05, 6'h00, 1, 1, 0, 0, 0);
        drive(6'h05, 6'h00, 1, 0, 0, 0, 0); #1 chk("bne_ne", pcsrcD, 1);
        step(6'h05, 6'h00, 1, 0, 0, 0, 0);

        step(6'h08, 6'h00, 1, 0, 0, 0, 3);
        for (int k = 0; k < 2; k++) begin
            step(6'h23, 6'h00, 1, 0, 0, 1, 3);
            chk("stall_alusrcE", alusrcE, 1);
            chk("stall_aluE", alucontrolE, 4'b0010);
            chk("stall_validM", validM, 0);
        end
        step(6'h23, 6'h00, 1, 0, 1, 1, 5);
        chk("flush_validE", validE, 0);
        chk("flush_rwE", regwriteE, 0);

        step(6'h00, 6'h02, 1, 0, 0, 0, 2);
        chk("srl_alu", alucontrolE, 4'b1001);
        chk("srl_shift", shiftE, 1);
        drive(6'h3f, 6'h00, 1, 0, 0, 0, 1); #1 chk("ill_D", illegalD, 1);
        step(6'h3f, 6'h00, 1, 0, 0, 0, 1);
        chk("ill_seen", illegal_seen, 1);
        sel = 3'd5; #1 chk("ill_dis31", disdata[31], 1);

        for (int n = 0; n < 400; n++) begin
            int oi;
            logic [5:0] op, f;
            oi = $urandom_range(0, 12);
            op = (oi == 12) ? 6'($urandom) : ops[oi];
            f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            step(op, f, $urandom_range(0, 5) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, 3'($urandom));
        end

        #2 rst_n = 1'b0; validD = 1'b0; sel = 3'd4;
        model_reset();
        #1;
        check_state();
        chk("mid_rst_dis4", disdata, 32'h0);
        sel = 3'd5; #1 chk("mid_rst_dis5", disdata, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            step(k < 5 ? 6'h08 : 6'h00, 6'h00, k < 5, 0, 0, 0, 4);
            chk("wrap_cnt", retire_cnt, exp_cnt[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_unit_v2.md
Name: pipe_ctrl_unit_v2

Overview:
Second-generation decode and control pipeline for the 5-stage MIPS core. It decodes opD/funcD in ID and carries control through the E/M/W pipeline registers, with E-stage flush and stall support. It adds bne, immediate ALU ops, shifts, illegal-op detection, valid tracking, a retired-instruction counter and an extended debug display mux. It sits beside the datapath and the hazard unit.

Parameters:
ALUC_W, 4, ALU control width; must be >=4; codes zero-extended into the upper bits.
CNT_W, 16, retire counter width, 1..32.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opD  in  6  ID opcode
funcD  in  6  ID funct field
validD  in  1  ID holds a real instruction; 0 decodes as a bubble
equalD  in  1  register compare result from ID
flushE  in  1  load a bubble into E
stallE  in  1  hold E
sel  in  3  display select
pcsrcD, branchD, jumpD, illegalD  out  1  ID decode outputs (combinational)
alusrcE, regdstE, shiftE, regwriteE, mem2regE  out  1  E controls
alucontrolE  out  ALUC_W  E ALU control
memwriteM, regwriteM, mem2regM  out  1  M controls
regwriteW, mem2regW  out  1  W controls
validE, validM, validW  out  1  stage valid flags
retire_cnt  out  CNT_W  count of instructions retired from W
illegal_seen  out  1  sticky illegal-opcode flag
disdata  out  32  debug display word

Behaviour:
- Decode (combinational). All signals not listed are 0.
  - R-type 000000: regwrite, regdst. funct 100000 add=0010, 100010 sub=0110, 100100 and=0000, 100101 or=0001, 101010 slt=0111, 000000 sll=1000 with shift=1, 000010 srl=1001 with shift=1.
  - lw 100011: regwrite, alusrc, mem2reg, add.
  - sw 101011: memwrite, alusrc, add.
  - beq 000100 and bne 000101: branch, sub.
  - addi 001000: add. andi 001100: and. ori 001101: or. slti 001010: slt. All four also assert regwrite and alusrc.
  - j 000010: jump.
- Any other op, or an R-type with another funct: illegalD=1 and all controls 0.
- validD=0: all controls 0, illegalD=0.
- pcsrcD = branchD & (beq ? equalD : ~equalD).
- reset low: every register and output-driving register clears to 0 immediately, without waiting for clk.
- E register (controls plus validE), per edge:
  - flushE=1: zeros. flushE has priority over stallE.
  - else stallE=1: hold.
  - else load the ID decode.
- M register, per edge:
  - stallE=1 and flushE=0: load a bubble (zeros), so the held instruction is not duplicated.
  - otherwise load E (memwrite, regwrite, mem2reg, valid).
- W register: loads M every edge.
- Latency: ID to E, M and W is 1, 2 and 3 edges when there is no stall or flush.
- retire_cnt: +1 on each edge where validW=1. Wraps from 2^CNT_W-1 to 0.
- illegal_seen: set on an edge where validD & illegalD & ~flushE & ~stallE. Cleared only by reset.
- disdata (combinational, indexed by sel). Each 1-bit flag occupies the LSB of its own nibble.
  - sel 0: nibbles hold mem2regE, mem2regM, mem2regW, branchD, regwriteE, regwriteM, regwriteW, regdstE (MSB nibble first).
  - sel 1: upper 2 nibbles 0; nibbles 5..0 each replicate opD[5..0].
  - sel 2: same layout as sel 1 using funcD.
  - sel 3: alucontrolE[3:0] in every nibble.
  - sel 4: retire_cnt zero-extended to 32 bits.
  - sel 5: bit31=illegal_seen, bits2:0={validE,validM,validW}, all other bits 0.
  - sel 6, 7: 0.

Test Plan:
- Reset: drive reset=0 mid-stream with no clock edge -> all outputs 0 immediately, disdata=0 for sel 4 and sel 5.
- Pipeline fill: lw (100011) with validD=1, then bubbles -> mem2regE=1 after edge 1, mem2regM=1 and memwriteM=0 after edge 2, mem2regW=1 and regwriteW=1 after edge 3; retire_cnt=1 after edge 4.
- Branches: beq with equalD=1 -> pcsrcD=1. bne with equalD=1 -> pcsrcD=0. bne with equalD=0 -> pcsrcD=1.
- Stall/flush: an E-stage addi held with stallE=1 for 2 edges -> E unchanged and validM=0 for both edges. Assert flushE and stallE together -> E becomes 0.
- Shift/illegal: R-type funct 000010 -> alucontrolE=1001 and shiftE=1. op 111111 with validD=1 -> illegalD=1, illegal_seen=1 after the edge, and sel=5 gives bit31=1.
- Wrap: CNT_W=2, five retired instructions -> retire_cnt sequence 1,2,3,0,1.
